// File: rtl/vptl_gate_pkg.sv
// Shared opcode encoding and per-bit gate evaluation for the gate bank pipe.
package vptl_gate_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_NAND = 3'd2,
    OP_OR   = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

  localparam gate_op_e OP_RST = OP_AND;

  // Operand b is a don't-care for the single-input ops (NOT, BUF).
  function automatic logic gate_eval(input gate_op_e op, input logic a, input logic b);
    logic z;
    unique case (op)
      OP_NOT:  z = ~a;
      OP_AND:  z = a & b;
      OP_NAND: z = ~(a & b);
      OP_OR:   z = a | b;
      OP_NOR:  z = ~(a | b);
      OP_XOR:  z = a ^ b;
      OP_XNOR: z = ~(a ^ b);
      default: z = a;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/vptl_sync_fifo.sv
// Power-of-two synchronous FIFO; when empty the output holds the last popped word.
module vptl_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/vptl_gate_bank_pipe.sv
// Bank of run-time programmable two-input gates feeding a result FIFO.
// Optional pop counter o_xfer_cnt is enabled by defining VPTL_GATE_STATS_EN.
module vptl_gate_bank_pipe
  import vptl_gate_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 2
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_cfg_sel,
  input  logic [OPW-1:0]                               i_cfg_op,
  input  logic                                         i_valid,
  output logic                                         o_ready,
  input  logic [CHANNELS*WIDTH-1:0]                    i_a,
  input  logic [CHANNELS*WIDTH-1:0]                    i_b,
  output logic                                         o_valid,
  input  logic                                         i_ready,
`ifdef VPTL_GATE_STATS_EN
  output logic [15:0]                                  o_xfer_cnt,
`endif
  output logic [CHANNELS*WIDTH-1:0]                    o_z
);

  gate_op_e op_q [CHANNELS];
  gate_op_e op_d [CHANNELS];

  logic [CHANNELS-1:0][WIDTH-1:0] res;
  logic                           accept, pop, fifo_full, fifo_empty;

  always_comb begin
    op_d = op_q;
    if (i_cfg_we && (int'(i_cfg_sel) < CHANNELS)) op_d[i_cfg_sel] = gate_op_e'(i_cfg_op);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < CHANNELS; k++) op_q[k] <= OP_RST;
    end else begin
      op_q <= op_d;
    end
  end

  // Evaluated from op_q, so a config write landing on the accept edge only affects later transfers.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    for (genvar bt = 0; bt < WIDTH; bt++) begin : g_bit
      assign res[ch][bt] = gate_eval(op_q[ch], i_a[ch*WIDTH+bt], i_b[ch*WIDTH+bt]);
    end
  end

  assign accept  = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  assign o_ready = !fifo_full;
  assign o_valid = !fifo_empty;

  vptl_sync_fifo #(
    .WIDTH (CHANNELS*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (accept),
    .din   (res),
    .pop   (pop),
    .dout  (o_z),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef VPTL_GATE_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (pop && (xfer_cnt_q != 16'hFFFF)) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) xfer_cnt_q <= '0;
    else       xfer_cnt_q <= xfer_cnt_d;
  end

  assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_vptl_gate_bank_pipe.sv
// Directed and randomized checks of vptl_gate_bank_pipe against a queue-based reference model.
module tb_vptl_gate_bank_pipe;

  localparam int CH = 4;
  localparam int W  = 1;
  localparam int D  = 2;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cfg_we = 1'b0;
  logic [1:0] i_cfg_sel = '0;
  logic [2:0] i_cfg_op = '0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic [3:0] i_a = '0;
  logic [3:0] i_b = '0;
  logic       o_ready, o_valid;
  logic [3:0] o_z;
`ifdef VPTL_GATE_STATS_EN
  logic [15:0] o_xfer_cnt;
`endif

  vptl_gate_bank_pipe #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_cfg_we  (i_cfg_we),
    .i_cfg_sel (i_cfg_sel),
    .i_cfg_op  (i_cfg_op),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
`ifdef VPTL_GATE_STATS_EN
    .o_xfer_cnt(o_xfer_cnt),
`endif
    .o_z       (o_z)
  );

  always #5 i_clk = ~i_clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         mop [CH];
  logic [3:0] mq [$];
  int         mpops = 0;

  // Truth table per opcode number, applied bit by bit.
  function automatic logic [3:0] ref_eval(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] z;
    for (int k = 0; k < CH; k++) begin
      case (mop[k])
        0: z[k] = !a[k];
        1: z[k] = a[k] && b[k];
        2: z[k] = !(a[k] && b[k]);
        3: z[k] = a[k] || b[k];
        4: z[k] = !(a[k] || b[k]);
        5: z[k] = a[k] != b[k];
        6: z[k] = a[k] == b[k];
        default: z[k] = a[k];
      endcase
    end
    return z;
  endfunction

  // Advance one clock; the model sees the same inputs and uses pre-edge opcodes for the push.
  task automatic tick();
    bit acc, pp;
    acc = i_valid && (mq.size() < D);
    pp  = i_ready && (mq.size() > 0);
    @(posedge i_clk);
    if (pp) begin
      void'(mq.pop_front());
      mpops++;
    end
    if (acc) mq.push_back(ref_eval(i_a, i_b));
    if (i_cfg_we) mop[i_cfg_sel] = int'(i_cfg_op);
    @(negedge i_clk);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < CH; k++) mop[k] = 1;
    mpops = 0;
  endtask

  task automatic do_reset();
    i_valid = 0; i_cfg_we = 0; i_ready = 0;
    i_rst = 1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    i_rst = 1;
    @(negedge i_clk);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
    n_chk++; if (o_z !== 4'b0000) begin n_fail++; $display("FAIL reset_o_z: got %b want 0000", o_z); end
    i_rst = 0;
    model_reset();
  endtask

  task automatic test_defaults();
    do_reset();
    i_ready = 1; i_a = 4'b1100; i_b = 4'b1010; i_valid = 1;
    tick();
    i_valid = 0;
    n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL default_o_valid: got %b want 1", o_valid); end
    n_chk++; if (o_z !== 4'b1000) begin n_fail++; $display("FAIL default_o_z: got %b want 1000", o_z); end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL default_o_ready: got %b want 1", o_ready); end
    tick();
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL default_drain: got o_valid %b want 0", o_valid); end
  endtask

  task automatic test_mixed_ops();
    int ops [CH] = '{0, 2, 3, 5};
    do_reset();
    i_ready = 1;
    for (int k = 0; k < CH; k++) begin
      i_cfg_we = 1; i_cfg_sel = 2'(k); i_cfg_op = 3'(ops[k]);
      tick();
    end
    i_cfg_we = 0;
    i_a = 4'b1100; i_b = 4'b1010; i_valid = 1;
    tick();
    i_valid = 0;
    n_chk++; if (o_valid !== 1'b1 || o_z !== 4'b0111) begin n_fail++; $display("FAIL mixed_ops: got v=%b z=%b want v=1 z=0111", o_valid, o_z); end
    n_chk++; if (o_z !== mq[0]) begin n_fail++; $display("FAIL mixed_model: got %b want %b", o_z, mq[0]); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    i_ready = 0; i_a = 4'b1111;
    i_valid = 1; i_b = 4'b0001; tick();
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", o_ready); end
    i_b = 4'b0010; tick();
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got o_ready %b want 0", o_ready); end
    i_b = 4'b0100; tick();
    n_chk++; if (o_ready !== 1'b0 || o_z !== 4'b0001) begin n_fail++; $display("FAIL bp_hold: got r=%b z=%b want r=0 z=0001", o_ready, o_z); end
    i_ready = 1; tick();
    n_chk++; if (o_ready !== 1'b1 || o_z !== 4'b0010) begin n_fail++; $display("FAIL bp_pop1: got r=%b z=%b want r=1 z=0010", o_ready, o_z); end
    tick();
    i_valid = 0;
    n_chk++; if (o_valid !== 1'b1 || o_z !== 4'b0100) begin n_fail++; $display("FAIL bp_third: got v=%b z=%b want v=1 z=0100", o_valid, o_z); end
    tick();
    n_chk++; if (o_valid !== 1'b0 || mq.size() != 0) begin n_fail++; $display("FAIL bp_empty: got v=%b want 0", o_valid); end
  endtask

  task automatic test_collision();
    do_reset();
    i_ready = 1;
    i_cfg_we = 1; i_cfg_sel = 2'd0; i_cfg_op = 3'd5;
    i_valid = 1; i_a = 4'b0001; i_b = 4'b0001;
    tick();
    i_cfg_we = 0;
    n_chk++; if (o_valid !== 1'b1 || o_z !== 4'b0001) begin n_fail++; $display("FAIL collide_old_op: got v=%b z=%b want v=1 z=0001", o_valid, o_z); end
    tick();
    i_valid = 0;
    n_chk++; if (o_valid !== 1'b1 || o_z !== 4'b0000) begin n_fail++; $display("FAIL collide_new_op: got v=%b z=%b want v=1 z=0000", o_valid, o_z); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_cfg_we = 1; i_cfg_sel = 2'd0; i_cfg_op = 3'd0;
    tick();
    i_cfg_we = 0;
    i_ready = 0; i_valid = 1; i_a = 4'b1100; i_b = 4'b1010;
    tick(); tick();
    i_valid = 0;
    n_chk++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full: got r=%b v=%b want r=0 v=1", o_ready, o_valid); end
    #2 i_rst = 1;
    #1;
    n_chk++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async: got v=%b r=%b want v=0 r=1", o_valid, o_ready); end
    @(negedge i_clk);
    i_rst = 0;
    model_reset();
    i_ready = 1; i_valid = 1;
    tick();
    i_valid = 0;
    n_chk++; if (o_valid !== 1'b1 || o_z !== 4'b1000) begin n_fail++; $display("FAIL mid_ops_and: got v=%b z=%b want v=1 z=1000", o_valid, o_z); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      i_valid   = 1'($urandom_range(0, 1));
      i_ready   = ($urandom_range(0, 3) != 0);
      i_a       = 4'($urandom);
      i_b       = 4'($urandom);
      i_cfg_we  = ($urandom_range(0, 5) == 0);
      i_cfg_sel = 2'($urandom);
      i_cfg_op  = 3'($urandom);
      n_chk++; if (o_ready !== (mq.size() < D)) begin n_fail++; $display("FAIL rand_ready @%0d: got %b want %b", n, o_ready, mq.size() < D); end
      n_chk++; if (o_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_valid @%0d: got %b want %b", n, o_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_chk++; if (o_z !== mq[0]) begin n_fail++; $display("FAIL rand_z @%0d: got %b want %b", n, o_z, mq[0]); end
      end
      tick();
    end
    i_valid = 0; i_cfg_we = 0;
  endtask

`ifdef VPTL_GATE_STATS_EN
  task automatic test_stats();
    do_reset();
    i_ready = 1; i_a = 4'b1111; i_b = 4'b1010; i_valid = 1;
    repeat (5) tick();
    i_valid = 0;
    repeat (3) tick();
    n_chk++; if (o_xfer_cnt !== 16'd5) begin n_fail++; $display("FAIL stats_count: got %0d want 5", o_xfer_cnt); end
    force dut.xfer_cnt_q = 16'hFFFE;
    #1 release dut.xfer_cnt_q;
    i_valid = 1;
    repeat (3) tick();
    i_valid = 0;
    repeat (3) tick();
    n_chk++; if (o_xfer_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat: got %h want ffff", o_xfer_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    @(negedge i_clk);
    test_reset();
    test_defaults();
    test_mixed_ops();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_random();
`ifdef VPTL_GATE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
